pipelined_adder_with_enable: RTL and testbench
==============================================

# pipelined_adder_with_enable

Parametrised, pipelined two's-complement add/subtract unit that succeeds the combinational 8-bit adder with enable. Operands of WIDTH bits are split into CHUNK-bit slices, one slice resolved per pipeline stage, with the carry registered between stages, so throughput is one operation per clock at any width. A global Enable freezes the whole pipeline, a valid flag tracks each operation, and a Mode input selects add or subtract with signed-overflow detection. The block sits in the datapath wherever the 8-bit adder was used and a wider or faster adder is now needed.

## Interface
- WIDTH, 8: operand and result width. Must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per stage. STAGES = WIDTH/CHUNK gives the latency in cycles. CHUNK = WIDTH gives a single-stage adder.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- Enable  input  1  pipeline advance. 0 freezes every register.
- In_valid  input  1  A/B/Cin0/Mode carry a new operation this cycle.
- Mode  input  1  0 = add (A+B+Cin0). 1 = subtract (A−B, Cin0 ignored).
- Cin0  input  1  carry in for add mode.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sum  output  WIDTH  result, low WIDTH bits.
- Cout  output  1  carry out of the MSB. In subtract mode this is the raw carry: 1 = no borrow.
- Overflow  output  1  signed overflow, equal to carry into the MSB XOR carry out of the MSB.
- Out_valid  output  1  Sum/Cout/Overflow hold a completed operation.

## Operation
- Operand conditioning at the input: B' = Mode ? ~B : B. Carry-in c0 = Mode ? 1 : Cin0.
- Stage k (k = 0..STAGES−1) adds slice k of A and B' plus the carry registered from stage k−1. Stage 0 uses c0.
- Slices above k are carried forward in skew registers. Sum slices below k are carried forward in alignment registers.
- The last stage also computes the carry into bit WIDTH−1 for Overflow.
- A valid bit travels with each operation. Bubbles (In_valid=0 while Enable=1) propagate as invalid entries.
- Results from invalid entries may contain any data. When Out_valid=0, the outputs hold their last valid values.
- No backpressure: the consumer must take a result in the cycle Out_valid=1 while Enable=1.
- Arithmetic is modulo 2^WIDTH. Cout and Overflow are the only indications that the result exceeded the range.

## Timing
- Reset: on a rising edge with rst=1, all pipeline registers clear. Sum=0, Cout=0, Overflow=0, Out_valid=0 from that edge.
- rst takes priority over Enable. A reset while operations are in flight discards them: no Out_valid for any of them.
- Capture: an operation is accepted at an edge where Enable=1 and In_valid=1.
- Latency: the result appears with Out_valid=1 after exactly STAGES further Enable=1 edges. Example: WIDTH=8, CHUNK=4 gives 2 cycles.
- Enable=0: no register changes, including the outputs and Out_valid. In_valid is ignored, so an operation presented during a freeze is lost and must be re-presented.
- While frozen, Out_valid=1 persists. The consumer takes the result once, at the next Enable=1 edge or the current one.
- Back-to-back: a new operation can be accepted every Enable=1 cycle. Results come out in order with no gaps beyond the input gaps.
- Mode and Cin0 are sampled with the operands. Mode may change every cycle, and operations of mixed Mode in flight do not interfere.

## Test plan
- WIDTH=8, CHUNK=4, Mode=0: A=0x00, B=0x01, Cin0=0 -> 2 cycles later Sum=0x01, Cout=0, Overflow=0, Out_valid=1.
- Carry across slice and MSB: A=0xFF, B=0x01 gives Sum=0x00, Cout=1. A=0xFF, B=0x00, Cin0=1 also gives Sum=0x00, Cout=1. A=0x0F, B=0x01 gives Sum=0x10, Cout=0.
- Subtract: A=0x05, B=0x07 gives Sum=0xFE, Cout=0, Overflow=0. A=0x80, B=0x01 gives Sum=0x7F, Cout=1, Overflow=1. A=0x7F, B=0x01 in add mode gives Sum=0x80, Overflow=1.
- Stream five mixed add/sub operations back-to-back with Enable=0 for 3 cycles mid-stream -> all five results in order, each Out_valid for exactly one Enable=1 edge, outputs stable while frozen, no duplicates.
- Pulse rst for one cycle with two operations in flight -> all outputs 0 after the reset edge, and no Out_valid for the discarded operations. An operation issued next cycle returns correctly after 2 cycles.
- Parameter sweep (WIDTH, CHUNK) ∈ {(8,8), (16,4), (32,8)} with random operands and modes -> every result matches a reference model of A±B within 2^WIDTH, with Cout and Overflow correct and latency = WIDTH/CHUNK.

Source files
------------

// File: rtl/pipelined_adder_with_enable.sv
// Pipelined add/subtract unit: one CHUNK-bit slice per stage, carry registered
// between stages, global Enable freeze and a valid bit per operation.
module pipelined_adder_with_enable #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Enable,
   input  logic             In_valid,
   input  logic             Mode,
   input  logic             Cin0,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow,
   output logic             Out_valid
);

   localparam int STAGES = WIDTH / CHUNK;

   // Level k registers feed stage k; level 0 holds the conditioned operands.
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] v_q;

   logic [WIDTH-1:0]  s_n [STAGES];
   logic [STAGES-1:0] c_n;
   logic [CHUNK:0]    t;
   logic              msb_cin;

   always_comb begin
      t   = '0;
      c_n = '0;
      for (int k = 0; k < STAGES; k++) begin
         t = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
           + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_q[k]};
         s_n[k] = s_q[k];
         s_n[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
         c_n[k] = t[CHUNK];
      end
   end

   // Carry into the MSB recovered from the MSB sum bit and its operands.
   assign msb_cin = a_q[STAGES-1][WIDTH-1]
                  ^ b_q[STAGES-1][WIDTH-1]
                  ^ s_n[STAGES-1][WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q       <= '0;
         v_q       <= '0;
         Sum       <= '0;
         Cout      <= 1'b0;
         Overflow  <= 1'b0;
         Out_valid <= 1'b0;
      end else if (Enable) begin
         v_q[0] <= In_valid;
         a_q[0] <= A;
         b_q[0] <= Mode ? ~B : B;
         c_q[0] <= Mode | Cin0;
         s_q[0] <= '0;
         for (int k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
            s_q[k] <= s_n[k-1];
            c_q[k] <= c_n[k-1];
         end
         Out_valid <= v_q[STAGES-1];
         // Bubbles leave the last valid result on the outputs.
         if (v_q[STAGES-1]) begin
            Sum      <= s_n[STAGES-1];
            Cout     <= c_n[STAGES-1];
            Overflow <= msb_cin ^ c_n[STAGES-1];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder_with_enable.sv
// Bench for pipelined_adder_with_enable: directed 8/4 vectors, stream with
// freeze, reset flush, and a random sweep over three parameter sets.
module tb_pipelined_adder_with_enable;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       mode;
      logic [7:0] s;
      logic       c;
      logic       o;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      int          cap;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_bad = 0;

   logic       rst, en, iv, mode, cin;
   logic [7:0] a, b, sum;
   logic       cout, ovf, ov;

   pipelined_adder_with_enable #(.WIDTH(8), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .Enable(en), .In_valid(iv), .Mode(mode),
      .Cin0(cin), .A(a), .B(b), .Sum(sum), .Cout(cout),
      .Overflow(ovf), .Out_valid(ov)
   );

   logic        sw_en, sw_iv, sw_mode, sw_cin;
   logic [31:0] sw_a, sw_b;
   logic [7:0]  s88;
   logic [15:0] s164;
   logic [31:0] s328;
   logic [2:0]  sw_c, sw_o, sw_ov;

   pipelined_adder_with_enable #(.WIDTH(8), .CHUNK(8)) p88 (
      .clk(clk), .rst(rst), .Enable(sw_en), .In_valid(sw_iv),
      .Mode(sw_mode), .Cin0(sw_cin), .A(sw_a[7:0]), .B(sw_b[7:0]),
      .Sum(s88), .Cout(sw_c[0]), .Overflow(sw_o[0]), .Out_valid(sw_ov[0])
   );
   pipelined_adder_with_enable #(.WIDTH(16), .CHUNK(4)) p164 (
      .clk(clk), .rst(rst), .Enable(sw_en), .In_valid(sw_iv),
      .Mode(sw_mode), .Cin0(sw_cin), .A(sw_a[15:0]), .B(sw_b[15:0]),
      .Sum(s164), .Cout(sw_c[1]), .Overflow(sw_o[1]), .Out_valid(sw_ov[1])
   );
   pipelined_adder_with_enable #(.WIDTH(32), .CHUNK(8)) p328 (
      .clk(clk), .rst(rst), .Enable(sw_en), .In_valid(sw_iv),
      .Mode(sw_mode), .Cin0(sw_cin), .A(sw_a), .B(sw_b),
      .Sum(s328), .Cout(sw_c[2]), .Overflow(sw_o[2]), .Out_valid(sw_ov[2])
   );

   logic [31:0] sw_sum [3];
   assign sw_sum[0] = {24'h0, s88};
   assign sw_sum[1] = {16'h0, s164};
   assign sw_sum[2] = s328;

   int wid [3] = '{8, 16, 32};
   int lat [3] = '{1, 4, 4};

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain modular arithmetic, overflow from operand/result signs.
   function automatic exp_t model(input int w, input logic [31:0] x,
                                  input logic [31:0] y, input logic ci,
                                  input logic md, input int cap);
      exp_t e;
      longint unsigned m, xx, yy, full;
      logic sx, sy, ss;
      m    = (64'd1 << w) - 64'd1;
      xx   = 64'(x) & m;
      yy   = md ? (~64'(y)) & m : 64'(y) & m;
      full = xx + yy + (md ? 64'd1 : 64'(ci));
      e.s  = 32'(full & m);
      e.c  = ((full >> w) & 64'd1) != 0;
      sx   = x[w-1];
      sy   = y[w-1];
      ss   = e.s[w-1];
      e.o  = md ? (sx != sy && ss != sx) : (sx == sy && ss != sx);
      e.cap = cap;
      return e;
   endfunction

   exp_t q_main [$];
   logic mon_on = 1'b0;
   logic prev_frz = 1'b0;
   logic [10:0] snap;
   int pops = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         if (prev_frz)
            chk("frozen_hold", {53'h0, ov, sum, cout, ovf}, {53'h0, snap});
         if (ov && en) begin
            if (q_main.size() == 0) begin
               chk("stream_extra", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = q_main.pop_front();
               chk("stream_res", {54'h0, sum, cout, ovf},
                   {54'h0, e.s[7:0], e.c, e.o});
               pops++;
            end
         end
         prev_frz = !en;
         snap = {ov, sum, cout, ovf};
      end
   end

   exp_t q_sw [3][$];
   logic sw_on = 1'b0;

   always @(negedge clk) begin
      if (sw_on) begin
         for (int j = 0; j < 3; j++) begin
            if (sw_ov[j]) begin
               if (q_sw[j].size() == 0) begin
                  chk($sformatf("sweep_extra%0d", j), 64'd1, 64'd0);
               end else begin
                  exp_t e;
                  e = q_sw[j].pop_front();
                  chk($sformatf("sweep_res%0d", j),
                      {30'h0, sw_sum[j], sw_c[j], sw_o[j]},
                      {30'h0, e.s, e.c, e.o});
                  chk($sformatf("sweep_lat%0d", j),
                      64'(cyc - e.cap), 64'(lat[j]));
               end
            end
         end
      end
   end

   vec_t tbl [10];
   int   s_idx [13] = '{0, 1, 2, -2, -1, -1, 3, 4, -1, -1, -1, -1, -1};
   logic s_en  [13] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
   logic [7:0] op_a [5] = '{8'h12, 8'h10, 8'h7F, 8'h80, 8'hF0};
   logic [7:0] op_b [5] = '{8'h34, 8'h20, 8'h7F, 8'h7F, 8'h20};
   logic       op_m [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic       op_c [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      tbl[0] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[3] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[8] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[9] = '{8'h7F, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};

      rst = 1'b1; en = 1'b1; iv = 1'b0; mode = 1'b0; cin = 1'b0;
      a = '0; b = '0;
      sw_en = 1'b1; sw_iv = 1'b0; sw_mode = 1'b0; sw_cin = 1'b0;
      sw_a = '0; sw_b = '0;
      step();
      step();
      chk("reset_state", {53'h0, ov, sum, cout, ovf}, 64'h0);
      rst = 1'b0;

      // Isolated vectors: latency, result, then hold after Out_valid drops.
      for (int i = 0; i < 10; i++) begin
         a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin; mode = tbl[i].mode;
         iv = 1'b1;
         step();
         iv = 1'b0;
         step();
         chk($sformatf("lat_early%0d", i), {63'h0, ov}, 64'h0);
         step();
         chk($sformatf("vec%0d", i), {53'h0, ov, sum, cout, ovf},
             {53'h0, 1'b1, tbl[i].s, tbl[i].c, tbl[i].o});
         step();
         chk($sformatf("hold%0d", i), {53'h0, ov, sum, cout, ovf},
             {53'h0, 1'b0, tbl[i].s, tbl[i].c, tbl[i].o});
      end

      // Back-to-back stream with a three-cycle freeze and a lost operation.
      mon_on = 1'b1;
      for (int i = 0; i < 13; i++) begin
         en = s_en[i];
         if (s_idx[i] >= 0) begin
            a = op_a[s_idx[i]]; b = op_b[s_idx[i]];
            mode = op_m[s_idx[i]]; cin = op_c[s_idx[i]];
            iv = 1'b1;
            if (en) q_main.push_back(model(8, {24'h0, a}, {24'h0, b},
                                           cin, mode, 0));
         end else if (s_idx[i] == -2) begin
            a = 8'h55; b = 8'hAA; mode = 1'b0; cin = 1'b1; iv = 1'b1;
         end else begin
            iv = 1'b0;
         end
         step();
      end
      mon_on = 1'b0;
      chk("stream_count", 64'(pops), 64'd5);
      chk("stream_left", 64'(q_main.size()), 64'd0);

      // Reset with two operations in flight, then a fresh operation.
      en = 1'b1; mode = 1'b0; cin = 1'b0;
      a = 8'h11; b = 8'h22; iv = 1'b1;
      step();
      a = 8'h33; b = 8'h44;
      step();
      iv = 1'b0; rst = 1'b1;
      step();
      chk("rst_flush", {53'h0, ov, sum, cout, ovf}, 64'h0);
      rst = 1'b0;
      a = 8'h21; b = 8'h09; mode = 1'b1; iv = 1'b1;
      step();
      iv = 1'b0;
      chk("rst_no_ov1", {63'h0, ov}, 64'h0);
      step();
      chk("rst_no_ov2", {63'h0, ov}, 64'h0);
      step();
      chk("rst_after", {53'h0, ov, sum, cout, ovf},
          {53'h0, 1'b1, 8'h18, 1'b1, 1'b0});

      // Random sweep across three parameter sets.
      sw_on = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (n == 0) begin
            sw_a = 32'hFFFF_FFFF; sw_b = 32'h1; sw_mode = 1'b0;
            sw_cin = 1'b0; sw_iv = 1'b1;
         end else if (n == 1) begin
            sw_a = 32'h8000_8080; sw_b = 32'h1; sw_mode = 1'b1;
            sw_cin = 1'b0; sw_iv = 1'b1;
         end else begin
            sw_a = $urandom; sw_b = $urandom;
            sw_mode = 1'($urandom_range(0, 1));
            sw_cin = 1'($urandom_range(0, 1));
            sw_iv = ($urandom_range(0, 3) != 0);
         end
         if (sw_iv)
            for (int j = 0; j < 3; j++)
               q_sw[j].push_back(model(wid[j], sw_a, sw_b, sw_cin,
                                       sw_mode, cyc + 1));
         step();
      end
      sw_iv = 1'b0;
      repeat (8) step();
      sw_on = 1'b0;
      for (int j = 0; j < 3; j++)
         chk($sformatf("sweep_drain%0d", j), 64'(q_sw[j].size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
